dmem_arbiter: RTL and testbench

- Shares the single-port 16-bit data memory between two requesters: port A (pipeline MEM stage, priority) and port B (loader/debug port).
- Sits between the requesters and the data memory; drives its addr, write_data, MemRead and MemWrite inputs and captures its combinational read data.
- Fixed priority to A, with a starvation counter that guarantees B forward progress.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_prio_starve.sv | 39 +++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding,
// default bus widths.
package dmem_arbiter_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_prio_starve.sv
// Fixed-priority A/B arbitration with a saturating starvation counter that
// lets B win once it has waited STARVE_LIMIT cycles.
module dmem_prio_starve #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic a_req,
  input  logic b_req,
  input  logic mask_a,
  input  logic mask_b,
  output logic grant_valid,
  output logic grant_b
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          a_v, b_v, starved;

  always_comb begin
    a_v         = a_req & ~mask_a;
    b_v         = b_req & ~mask_b;
    starved     = (starve_q >= SW'(STARVE_LIMIT));
    grant_valid = arb_en & (a_v | b_v);
    grant_b     = arb_en & b_v & (~a_v | starved);
    // B's own in-flight access (mask_b) is not waiting, so it does not count
    if (!b_req || mask_b || grant_b) starve_d = '0;
    else if (starved)                starve_d = starve_q;
    else                             starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: each access is
// one SERVE cycle on the memory bus followed by one RESP (ack) cycle.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int ALIGN_CHECK  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  output logic          a_stall,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic          b_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic          a_err_q, a_err_d, b_err_q, b_err_d;

  logic serve, resp, arb_en, mask_a, mask_b, misal;
  logic grant_valid, grant_b;

  assign serve  = (state_q == ST_SERVE);
  assign resp   = (state_q == ST_RESP);
  assign arb_en = (state_q == ST_IDLE) | resp;
  // the owner still holds req until it sees ack, so hide it from arbitration
  assign mask_a = (state_q != ST_IDLE) & (owner_q == OWN_A);
  assign mask_b = (state_q != ST_IDLE) & (owner_q == OWN_B);
  assign misal  = (ALIGN_CHECK != 0) & addr_q[0];

  dmem_prio_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .arb_en      (arb_en),
    .a_req       (a_req),
    .b_req       (b_req),
    .mask_a      (mask_a),
    .mask_b      (mask_b),
    .grant_valid (grant_valid),
    .grant_b     (grant_b)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_valid) state_d = ST_SERVE;
      ST_SERVE: state_d = ST_RESP;
      ST_RESP:  state_d = grant_valid ? ST_SERVE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // memory strobes come straight from state_q so reset kills them at once
  always_comb begin
    mem_read  = serve & ~we_q & ~misal;
    mem_write = serve &  we_q & ~misal;
    a_ack     = resp & (owner_q == OWN_A);
    b_ack     = resp & (owner_q == OWN_B);
    a_stall   = a_req & ~a_ack;
    b_stall   = b_req & ~b_ack;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_err     = a_err_q;
  assign b_err     = b_err_q;

  always_comb begin
    owner_d   = owner_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_err_d   = a_err_q;
    b_err_d   = b_err_q;
    if (grant_valid) begin
      owner_d = grant_b ? OWN_B   : OWN_A;
      addr_d  = grant_b ? b_addr  : a_addr;
      wdata_d = grant_b ? b_wdata : a_wdata;
      we_d    = grant_b ? b_we    : a_we;
    end
    if (serve) begin
      if (owner_q == OWN_A) begin
        a_err_d = misal;
        if (!we_q) a_rdata_d = misal ? '0 : mem_rdata;
      end else begin
        b_err_d = misal;
        if (!we_q) b_rdata_d = misal ? '0 : mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_A;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: two arbiters (ALIGN_CHECK 0 and 1) share requester inputs,
// each with its own little-endian byte memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;

  logic [1:0]  a_ack, a_err, a_stall, b_ack, b_err, b_stall, mem_read, mem_write;
  logic [15:0] a_rdata [2];
  logic [15:0] b_rdata [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic [15:0] ap1 [2];

  logic [7:0] mem [2][65536];

  int n_chk = 0;
  int n_err = 0;

  assign ap1[0]       = mem_addr[0] + 16'd1;
  assign ap1[1]       = mem_addr[1] + 16'd1;
  assign mem_rdata[0] = {mem[0][ap1[0]], mem[0][mem_addr[0]]};
  assign mem_rdata[1] = {mem[1][ap1[1]], mem[1][mem_addr[1]]};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_write[k]) begin
        mem[k][mem_addr[k]] <= mem_wdata[k][7:0];
        mem[k][ap1[k]]      <= mem_wdata[k][15:8];
      end
    end
  end

  dmem_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(4), .ALIGN_CHECK(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack[0]), .a_rdata(a_rdata[0]), .a_err(a_err[0]), .a_stall(a_stall[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack[0]), .b_rdata(b_rdata[0]), .b_err(b_err[0]), .b_stall(b_stall[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.AW(16), .DW(16), .STARVE_LIMIT(4), .ALIGN_CHECK(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack[1]), .a_rdata(a_rdata[1]), .a_err(a_err[1]), .a_stall(a_stall[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack[1]), .b_rdata(b_rdata[1]), .b_err(b_err[1]), .b_stall(b_stall[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .mem_rdata(mem_rdata[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  // complete one isolated port-A access: SERVE, RESP, back to IDLE
  task automatic a_xact(input logic we, input logic [15:0] addr, input logic [15:0] wd);
    set_a(1'b1, we, addr, wd);
    tick; tick;
    chk("setup_a_ack", 32'(a_ack[0]), 32'd1);
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    tick;
  endtask

  logic [7:0] exp_aack, exp_back;
  int         exp_s [8];

  initial begin
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    set_b(1'b0, 1'b0, 16'h0, 16'h0);
    tick; tick;
    // reset state
    chk("rst_mem_read",  32'(mem_read),  32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr[0]), 32'd0);
    chk("rst_acks",      32'({a_ack, b_ack}), 32'd0);
    chk("rst_errs",      32'({a_err, b_err}), 32'd0);
    chk("rst_a_rdata",   32'(a_rdata[0]), 32'd0);
    rst = 1'b1;
    tick;

    // 1: write then read back
    set_a(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    tick;
    chk("t1_wr_pulse", 32'(mem_write[0]), 32'd1);
    chk("t1_wr_addr",  32'(mem_addr[0]),  32'h0010);
    chk("t1_wr_data",  32'(mem_wdata[0]), 32'hBEEF);
    chk("t1_wr_noread", 32'(mem_read[0]), 32'd0);
    chk("t1_stall",    32'(a_stall[0]),   32'd1);
    tick;
    chk("t1_wr_ack",   32'(a_ack[0]),     32'd1);
    chk("t1_wr_drop",  32'(mem_write[0]), 32'd0);
    chk("t1_nostall",  32'(a_stall[0]),   32'd0);
    chk("t1_mem",      32'({mem[0][16'h0011], mem[0][16'h0010]}), 32'hBEEF);
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    tick;
    chk("t1_idle_nowr", 32'(mem_write[0]), 32'd0);
    set_a(1'b1, 1'b0, 16'h0010, 16'h0);
    tick;
    chk("t1_rd_pulse", 32'(mem_read[0]), 32'd1);
    chk("t1_rd_noack", 32'(a_ack[0]),    32'd0);
    tick;
    chk("t1_rd_ack",   32'(a_ack[0]),    32'd1);
    chk("t1_rd_data",  32'(a_rdata[0]),  32'hBEEF);
    chk("t1_rd_err",   32'(a_err[0]),    32'd0);
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    tick;

    // 2: simultaneous A read / B write, B follows straight from RESP
    a_xact(1'b1, 16'h0020, 16'h7788);
    set_a(1'b1, 1'b0, 16'h0020, 16'h0);
    set_b(1'b1, 1'b1, 16'h0030, 16'h1234);
    tick;
    chk("t2_sa_read",  32'(mem_read[0]), 32'd1);
    chk("t2_sa_addr",  32'(mem_addr[0]), 32'h0020);
    chk("t2_b_stall",  32'(b_stall[0]),  32'd1);
    chk("t2_starve1",  32'(u_dut0.u_arb.starve_q), 32'd1);
    tick;
    chk("t2_ra_ack",   32'({a_ack[0], b_ack[0]}), 32'b10);
    chk("t2_ra_data",  32'(a_rdata[0]), 32'h7788);
    chk("t2_ra_nomem", 32'({mem_read[0], mem_write[0]}), 32'd0);
    chk("t2_starve2",  32'(u_dut0.u_arb.starve_q), 32'd2);
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    tick;
    chk("t2_sb_write", 32'(mem_write[0]), 32'd1);
    chk("t2_sb_addr",  32'(mem_addr[0]),  32'h0030);
    chk("t2_sb_data",  32'(mem_wdata[0]), 32'h1234);
    chk("t2_sb_noack", 32'({a_ack[0], b_ack[0]}), 32'd0);
    chk("t2_starve0",  32'(u_dut0.u_arb.starve_q), 32'd0);
    tick;
    chk("t2_rb_ack",   32'(b_ack[0]), 32'd1);
    chk("t2_mem",      32'({mem[0][16'h0031], mem[0][16'h0030]}), 32'h1234);
    set_b(1'b0, 1'b0, 16'h0, 16'h0);
    tick;

    // 3: both requesting continuously -> strict alternation, starve bounded
    exp_aack = 8'b0010_0010;
    exp_back = 8'b1000_1000;
    exp_s    = '{1, 2, 0, 0, 0, 1, 0, 0};
    set_a(1'b1, 1'b0, 16'h0020, 16'h0);
    set_b(1'b1, 1'b0, 16'h0030, 16'h0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("t3_a_ack%0d", i), 32'(a_ack[0]), 32'(exp_aack[i]));
      chk($sformatf("t3_b_ack%0d", i), 32'(b_ack[0]), 32'(exp_back[i]));
      chk($sformatf("t3_starve%0d", i), 32'(u_dut0.u_arb.starve_q), 32'(exp_s[i]));
    end
    chk("t3_a_rdata", 32'(a_rdata[0]), 32'h7788);
    chk("t3_b_rdata", 32'(b_rdata[0]), 32'h1234);
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    set_b(1'b0, 1'b0, 16'h0, 16'h0);
    tick; tick;

    // 4: misaligned B read rejected on the ALIGN_CHECK=1 instance
    a_xact(1'b1, 16'h0040, 16'hC0DE);
    set_b(1'b1, 1'b0, 16'h0040, 16'h0);
    tick; tick;
    chk("t4_b_ack",    32'(b_ack[1]),   32'd1);
    chk("t4_b_rdata0", 32'(b_rdata[1]), 32'hC0DE);
    set_b(1'b0, 1'b0, 16'h0, 16'h0);
    tick;
    set_b(1'b1, 1'b0, 16'h0041, 16'h0);
    tick;
    chk("t4_no_access", 32'({mem_read[1], mem_write[1]}), 32'd0);
    chk("t4_pass_dut0", 32'(mem_read[0]), 32'd1);
    tick;
    chk("t4_mis_ack",   32'(b_ack[1]),   32'd1);
    chk("t4_mis_err",   32'(b_err[1]),   32'd1);
    chk("t4_mis_rdata", 32'(b_rdata[1]), 32'd0);
    chk("t4_dut0_err",  32'(b_err[0]),   32'd0);
    set_b(1'b0, 1'b0, 16'h0, 16'h0);
    tick;
    set_a(1'b1, 1'b0, 16'h0040, 16'h0);
    tick;
    chk("t4_a_read",   32'(mem_read[1]), 32'd1);
    tick;
    chk("t4_a_ack",    32'(a_ack[1]),   32'd1);
    chk("t4_a_rdata",  32'(a_rdata[1]), 32'hC0DE);
    chk("t4_a_err",    32'(a_err[1]),   32'd0);
    chk("t4_b_err_hold", 32'(b_err[1]), 32'd1);
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    tick;

    // 5: reset during SERVE of a write aborts it
    a_xact(1'b1, 16'h0050, 16'h1111);
    set_a(1'b1, 1'b1, 16'h0050, 16'hAAAA);
    tick;
    chk("t5_wr_pulse", 32'(mem_write[0]), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("t5_wr_killed", 32'(mem_write), 32'd0);
    chk("t5_rd_zero",   32'(mem_read),  32'd0);
    chk("t5_addr_zero", 32'(mem_addr[0]), 32'd0);
    chk("t5_wd_zero",   32'(mem_wdata[0]), 32'd0);
    chk("t5_acks",      32'({a_ack, b_ack}), 32'd0);
    chk("t5_a_rdata",   32'(a_rdata[0]), 32'd0);
    chk("t5_b_rdata",   32'(b_rdata[0]), 32'd0);
    chk("t5_errs",      32'({a_err, b_err}), 32'd0);
    chk("t5_starve",    32'(u_dut0.u_arb.starve_q), 32'd0);
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    tick;
    rst = 1'b1;
    chk("t5_mem_kept",  32'({mem[0][16'h0051], mem[0][16'h0050]}), 32'h1111);
    tick;
    set_a(1'b1, 1'b0, 16'h0050, 16'h0);
    tick; tick;
    chk("t5_rd_ack",    32'(a_ack[0]),   32'd1);
    chk("t5_rd_data",   32'(a_rdata[0]), 32'h1111);
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    tick;

    // 6: odd top address passes through and wraps in memory
    set_a(1'b1, 1'b1, 16'hFFFF, 16'h5A3C);
    tick;
    chk("t6_addr",  32'(mem_addr[0]),  32'hFFFF);
    chk("t6_write", 32'(mem_write[0]), 32'd1);
    tick;
    chk("t6_ack",   32'(a_ack[0]), 32'd1);
    chk("t6_lo",    32'(mem[0][16'hFFFF]), 32'h3C);
    chk("t6_hi",    32'(mem[0][16'h0000]), 32'h5A);
    chk("t6_dut1_err", 32'(a_err[1]), 32'd1);
    set_a(1'b0, 1'b0, 16'h0, 16'h0);
    tick;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
